// File: rtl/rat_pkg.sv
// ============================================================================
// rat_pkg : shared constants and direction codes for the rat datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rat_pkg;

  localparam int COORD_W = 4;

  localparam logic [COORD_W-1:0] STEP_INC = 4'b0001;
  localparam logic [COORD_W-1:0] STEP_DEC = 4'b1111;

  typedef enum logic [1:0] {
    DIR_0 = 2'd0,
    DIR_1 = 2'd1,
    DIR_2 = 2'd2,
    DIR_3 = 2'd3
  } dir_t;

endpackage

`default_nettype wire

// File: rtl/rat_step_counter.sv
// ============================================================================
// rat_step_counter : direction index counter with clear > load > increment
// Rev 1.0 : initial release. Optional trace under RAT_STEP_TRACE_EN.
// ============================================================================
`default_nettype none

module rat_step_counter
  import rat_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_clr,
  input  logic             cnt_ld,
  input  logic             cnt_inc,
  input  logic [CNT_W-1:0] cnt_ld_val,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cnt_co
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_ld) begin
      cnt_d = cnt_ld_val;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Deliberately not masked by clear/load: the controller owns that rule.
  assign cnt_co  = cnt_inc & (&cnt_q);
  assign cnt_val = cnt_q;

`ifdef RAT_STEP_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && (cnt_d != cnt_q)) begin
      $display("dir: %0d", cnt_d);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/rat_step_unit.sv
// ============================================================================
// rat_step_unit : coord +/-1 stepper with range flag, plus direction counter
// Rev 1.0 : initial release. Optional trace under RAT_STEP_TRACE_EN.
// ============================================================================
`default_nettype none

module rat_step_unit
  import rat_pkg::*;
#(
  parameter int WIDTH = COORD_W,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] coord,
  input  logic             dec,
  output logic [WIDTH-1:0] step_res,
  output logic             step_co,
  output logic             out_of_range,
  input  logic             cnt_clr,
  input  logic             cnt_ld,
  input  logic             cnt_inc,
  input  logic [CNT_W-1:0] cnt_ld_val,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cnt_co
);

  logic [WIDTH-1:0] w_step;

  generate
    if (WIDTH == COORD_W) begin : g_pkg_step
      assign w_step = dec ? STEP_DEC : STEP_INC;
    end else begin : g_gen_step
      assign w_step = dec ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1};
    end
  endgenerate

  assign {step_co, step_res} = {1'b0, coord} + {1'b0, w_step};

  // Decrement is +all-ones, so a missing carry means 0 wrapped to max.
  assign out_of_range = dec ? ~step_co : step_co;

  rat_step_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr    (cnt_clr),
    .cnt_ld     (cnt_ld),
    .cnt_inc    (cnt_inc),
    .cnt_ld_val (cnt_ld_val),
    .cnt_val    (cnt_val),
    .cnt_co     (cnt_co)
  );

`ifdef RAT_STEP_TRACE_EN
  always @(posedge clk) begin
    if (out_of_range) begin
      $display("oor: coord=%0d dec=%0b step_res=%0d", coord, dec, step_res);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rat_step_unit.sv
// ============================================================================
// tb_rat_step_unit : directed self-checking bench with expected-value queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rat_step_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] coord;
  logic       dec;
  logic [3:0] step_res;
  logic       step_co;
  logic       out_of_range;
  logic       cnt_clr;
  logic       cnt_ld;
  logic       cnt_inc;
  logic [1:0] cnt_ld_val;
  logic [1:0] cnt_val;
  logic       cnt_co;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  rat_step_unit #(
    .WIDTH (4),
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coord        (coord),
    .dec          (dec),
    .step_res     (step_res),
    .step_co      (step_co),
    .out_of_range (out_of_range),
    .cnt_clr      (cnt_clr),
    .cnt_ld       (cnt_ld),
    .cnt_inc      (cnt_inc),
    .cnt_ld_val   (cnt_ld_val),
    .cnt_val      (cnt_val),
    .cnt_co       (cnt_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t item;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) n_passed++;
      else $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
    end
  endtask

  // Packs {step_co, out_of_range, step_res} for the stepper checks.
  task automatic step_check(input int c, input logic d);
    int          res;
    logic        co;
    logic        oor;
    coord = 4'(c);
    dec   = d;
    if (!d) begin
      res = (c + 1) % 16;
      co  = (c == 15);
      oor = (c == 15);
    end else begin
      res = (c + 15) % 16;
      co  = (c != 0);
      oor = (c == 0);
    end
    sb_push($sformatf("step c=%0d dec=%0b", c, d), {26'd0, co, oor, 4'(res)});
    #1;
    sb_pop_check({26'd0, step_co, out_of_range, step_res});
  endtask

  // One counter cycle: drive at negedge, check cnt_co before the edge,
  // check cnt_val just after it.
  task automatic cnt_step(input string tag, input logic clr, input logic ld,
                          input logic inc, input logic [1:0] ldv,
                          input logic exp_co, input logic [1:0] exp_val);
    @(negedge clk);
    cnt_clr    = clr;
    cnt_ld     = ld;
    cnt_inc    = inc;
    cnt_ld_val = ldv;
    sb_push({tag, "_co"}, {31'd0, exp_co});
    sb_push({tag, "_val"}, {30'd0, exp_val});
    #1;
    sb_pop_check({31'd0, cnt_co});
    @(posedge clk);
    #1;
    sb_pop_check({30'd0, cnt_val});
  endtask

  initial begin
    rst_n      = 1'b0;
    coord      = '0;
    dec        = 1'b0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_inc    = 1'b0;
    cnt_ld_val = '0;

    // Reset state
    @(posedge clk);
    #1;
    sb_push("rst_val", 32'd0);
    sb_pop_check({30'd0, cnt_val});
    sb_push("rst_co", 32'd0);
    sb_pop_check({31'd0, cnt_co});

    // Stepper sweeps
    for (int c = 0; c < 16; c++) step_check(c, 1'b0);
    for (int c = 0; c < 16; c++) step_check(c, 1'b1);

    // Stepper ignores reset
    step_check(7, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;

    // 0,1,2,3,0 with carry only on the wrapping cycle
    cnt_step("inc0", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1);
    cnt_step("inc1", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2);
    cnt_step("inc2", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3);
    cnt_step("inc3", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);
    cnt_step("hold", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0);

    // Load beats increment
    cnt_step("ld2_inc", 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd2);
    cnt_step("inc_to3", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3);

    // Clear beats increment; carry still reads 1 at value 3
    cnt_step("clr_inc", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0);

    // Clear beats load
    cnt_step("ld3", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 2'd3);
    cnt_step("hold3", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd3);
    cnt_step("clr_ld", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0);

    // Async reset at value 2, between edges
    cnt_step("pre1", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1);
    cnt_step("pre2", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2);
    cnt_inc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("async_rst_val", 32'd0);
    sb_pop_check({30'd0, cnt_val});
    sb_push("async_rst_co", 32'd0);
    sb_pop_check({31'd0, cnt_co});
    @(negedge clk);
    rst_n = 1'b1;
    cnt_step("post_rst_inc", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1);

    if (sb_q.size() != 0) begin
      n_total++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

`default_nettype wire
